// File: rtl/cross_bar_slave_arb.sv
// Per-slave round-robin arbiter: grants one master, runs a single req/ack to the slave, returns ack/rdata.
// Grant in 1 cycle, ack to master 1 cycle after slave_ack; requests stall (held) while BUSY/DONE or on timeout.
module cross_bar_slave_arb #(
  parameter int MASTER_N    = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic [MASTER_N-1:0]                master_req,
  input  logic [MASTER_N-1:0][ADDR_W-1:0]    master_addr,
  input  logic [MASTER_N-1:0]                master_cmd,
  input  logic [MASTER_N-1:0][DATA_W-1:0]    master_wdata,
  output logic [MASTER_N-1:0]                master_ack,
  output logic [DATA_W-1:0]                  master_rdata,
  output logic                               slave_req,
  output logic [ADDR_W-1:0]                  slave_addr,
  output logic                               slave_cmd,
  output logic [DATA_W-1:0]                  slave_wdata,
  input  logic                               slave_ack,
  input  logic [DATA_W-1:0]                  slave_rdata,
  output logic [$clog2(MASTER_N)-1:0]        grant_id,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int PTR_W   = $clog2(MASTER_N);
  localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam bit TO_EN   = (TIMEOUT_CYC > 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [MASTER_N-1:0] served_mask;
  logic [CNT_W-1:0]    cnt;

  logic [MASTER_N-1:0] elig;
  logic                any_elig;
  logic [PTR_W-1:0]    win;
  logic [PTR_W-1:0]    win_next;
  logic [MASTER_N-1:0] gnt_onehot;
  int                  idx;

  assign elig       = master_req & ~served_mask;
  assign gnt_onehot = {{(MASTER_N-1){1'b0}}, 1'b1} << grant_id;
  assign win_next   = (win == PTR_W'(MASTER_N - 1)) ? '0 : win + 1'b1;
  assign busy       = (state != ST_IDLE);

  // First eligible index at or above rr_ptr, wrapping.
  always_comb begin
    any_elig = 1'b0;
    win      = '0;
    idx      = 0;
    for (int i = 0; i < MASTER_N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= MASTER_N) idx = idx - MASTER_N;
      if (!any_elig && elig[PTR_W'(idx)]) begin
        any_elig = 1'b1;
        win      = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aresetn) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      served_mask  <= '0;
      cnt          <= '0;
      slave_req    <= 1'b0;
      slave_addr   <= '0;
      slave_cmd    <= 1'b0;
      slave_wdata  <= '0;
      master_ack   <= '0;
      master_rdata <= '0;
      grant_id     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      master_ack  <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The just-served master is masked for this one cycle only.
          served_mask <= '0;
          if (any_elig) begin
            slave_addr  <= master_addr[win];
            slave_cmd   <= master_cmd[win];
            slave_wdata <= master_wdata[win];
            grant_id    <= win;
            rr_ptr      <= win_next;
            slave_req   <= 1'b1;
            cnt         <= '0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (slave_ack) begin
            master_rdata <= slave_rdata;
            slave_req    <= 1'b0;
            master_ack   <= gnt_onehot;
            state        <= ST_DONE;
          end else if (TO_EN && cnt == CNT_W'(TO_LAST)) begin
            master_rdata <= '0;
            slave_req    <= 1'b0;
            master_ack   <= gnt_onehot;
            timeout_err  <= 1'b1;
            state        <= ST_DONE;
          end else if (cnt != CNT_W'(TO_LAST)) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          served_mask <= gnt_onehot;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cross_bar_slave_arb.sv
// Directed bench for cross_bar_slave_arb: per-cycle vector table plus timeout, collision and reset sequences.
module tb_cross_bar_slave_arb;

  logic              clk;
  logic              aresetn;
  logic [3:0]        master_req;
  logic [3:0][31:0]  master_addr;
  logic [3:0]        master_cmd;
  logic [3:0][31:0]  master_wdata;
  logic [3:0]        master_ack;
  logic [31:0]       master_rdata;
  logic              slave_req;
  logic [31:0]       slave_addr;
  logic              slave_cmd;
  logic [31:0]       slave_wdata;
  logic              slave_ack;
  logic [31:0]       slave_rdata;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  cross_bar_slave_arb #(
    .MASTER_N(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .master_req(master_req), .master_addr(master_addr), .master_cmd(master_cmd),
    .master_wdata(master_wdata), .master_ack(master_ack), .master_rdata(master_rdata),
    .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd),
    .slave_wdata(slave_wdata), .slave_ack(slave_ack), .slave_rdata(slave_rdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  cmd;
    logic        sack;
    logic [31:0] srd;
    logic        e_sreq;
    logic [3:0]  e_mack;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] cmd,
                     input logic sack, input logic [31:0] srd, input logic e_sreq,
                     input logic [3:0] e_mack, input logic [1:0] e_gid,
                     input logic e_busy, input logic [31:0] e_rd);
    vec_t v;
    v.rst = rst; v.req = req; v.cmd = cmd; v.sack = sack; v.srd = srd;
    v.e_sreq = e_sreq; v.e_mack = e_mack; v.e_gid = e_gid; v.e_busy = e_busy; v.e_rd = e_rd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    aresetn     = 1'b1;
    master_req  = '0;
    master_cmd  = '0;
    slave_ack   = 1'b0;
    slave_rdata = '0;
    master_addr[0] = 32'h2000_0000;
    master_addr[1] = 32'h1000_0100;
    master_addr[2] = 32'h1000_0010;
    master_addr[3] = 32'h3000_0030;
    master_wdata[0] = 32'h0000_0A00;
    master_wdata[1] = 32'hDEAD_BEEF;
    master_wdata[2] = 32'h0000_0A02;
    master_wdata[3] = 32'h0000_0A03;

    //  rst  req      cmd      sack srd            sreq mack     gid   busy rdata
    add(1, 4'b0000, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd0, 0, 32'h0);
    add(0, 4'b0100, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd2, 1, 32'h0);
    add(0, 4'b0100, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd2, 1, 32'h0);
    add(0, 4'b0100, 4'b0000, 1, 32'hA5A5_0001,  0, 4'b0100, 2'd2, 1, 32'hA5A5_0001);
    add(0, 4'b0000, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd2, 0, 32'hA5A5_0001);
    add(0, 4'b0000, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd2, 0, 32'hA5A5_0001);
    add(1, 4'b1111, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd0, 0, 32'h0);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd0, 1, 32'h0);
    add(0, 4'b1111, 4'b0000, 1, 32'h11,         0, 4'b0001, 2'd0, 1, 32'h11);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd0, 0, 32'h11);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd1, 1, 32'h11);
    add(0, 4'b1111, 4'b0000, 1, 32'h22,         0, 4'b0010, 2'd1, 1, 32'h22);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd1, 0, 32'h22);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd2, 1, 32'h22);
    add(0, 4'b1111, 4'b0000, 1, 32'h33,         0, 4'b0100, 2'd2, 1, 32'h33);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd2, 0, 32'h33);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd3, 1, 32'h33);
    add(0, 4'b1111, 4'b0000, 1, 32'h44,         0, 4'b1000, 2'd3, 1, 32'h44);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd3, 0, 32'h44);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd0, 1, 32'h44);
    add(0, 4'b1111, 4'b0000, 1, 32'h55,         0, 4'b0001, 2'd0, 1, 32'h55);
    add(0, 4'b1111, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd0, 0, 32'h55);
    // master 0 alone right after its own DONE: masked for one cycle
    add(0, 4'b0001, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd0, 0, 32'h55);
    add(0, 4'b0001, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd0, 1, 32'h55);
    add(0, 4'b0001, 4'b0000, 1, 32'h66,         0, 4'b0001, 2'd0, 1, 32'h66);
    add(0, 4'b0000, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd0, 0, 32'h66);
    // write from master 1, ack held high for 3 cycles
    add(0, 4'b0010, 4'b0010, 0, 32'h0,          1, 4'b0000, 2'd1, 1, 32'h66);
    add(0, 4'b0010, 4'b0010, 1, 32'h77,         0, 4'b0010, 2'd1, 1, 32'h77);
    add(0, 4'b0000, 4'b0010, 1, 32'h77,         0, 4'b0000, 2'd1, 0, 32'h77);
    add(0, 4'b0000, 4'b0010, 1, 32'h77,         0, 4'b0000, 2'd1, 0, 32'h77);
    add(0, 4'b0000, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd1, 0, 32'h77);
    // master 3 drops its request mid-BUSY; transaction still completes
    add(0, 4'b1000, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd3, 1, 32'h77);
    add(0, 4'b0000, 4'b0000, 0, 32'h0,          1, 4'b0000, 2'd3, 1, 32'h77);
    add(0, 4'b0000, 4'b0000, 1, 32'h88,         0, 4'b1000, 2'd3, 1, 32'h88);
    add(0, 4'b0000, 4'b0000, 0, 32'h0,          0, 4'b0000, 2'd3, 0, 32'h88);

    foreach (vq[i]) begin
      aresetn     = vq[i].rst;
      master_req  = vq[i].req;
      master_cmd  = vq[i].cmd;
      slave_ack   = vq[i].sack;
      slave_rdata = vq[i].srd;
      step();
      chk($sformatf("v%0d slave_req", i),    64'(slave_req),    64'(vq[i].e_sreq));
      chk($sformatf("v%0d master_ack", i),   64'(master_ack),   64'(vq[i].e_mack));
      chk($sformatf("v%0d grant_id", i),     64'(grant_id),     64'(vq[i].e_gid));
      chk($sformatf("v%0d busy", i),         64'(busy),         64'(vq[i].e_busy));
      chk($sformatf("v%0d timeout_err", i),  64'(timeout_err),  64'(0));
      chk($sformatf("v%0d master_rdata", i), 64'(master_rdata), 64'(vq[i].e_rd));
      if (vq[i].rst) begin
        chk($sformatf("v%0d rst slave_addr", i),  64'(slave_addr),  64'(0));
        chk($sformatf("v%0d rst slave_cmd", i),   64'(slave_cmd),   64'(0));
        chk($sformatf("v%0d rst slave_wdata", i), 64'(slave_wdata), 64'(0));
      end else if (vq[i].e_sreq) begin
        chk($sformatf("v%0d slave_addr", i),  64'(slave_addr),  64'(master_addr[vq[i].e_gid]));
        chk($sformatf("v%0d slave_cmd", i),   64'(slave_cmd),   64'(vq[i].cmd[vq[i].e_gid]));
        chk($sformatf("v%0d slave_wdata", i), 64'(slave_wdata), 64'(master_wdata[vq[i].e_gid]));
      end
    end

    // Timeout: rr_ptr is 0 here, master 0 granted, slave never acks
    master_req = 4'b0001; master_cmd = '0; slave_ack = 1'b0; slave_rdata = 32'hFFFF_FFFF;
    step();
    chk("to grant_id", 64'(grant_id), 64'(0));
    chk("to slave_req", 64'(slave_req), 64'(1));
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("to busy%0d master_ack", i), 64'(master_ack), 64'(0));
      chk($sformatf("to busy%0d timeout_err", i), 64'(timeout_err), 64'(0));
      chk($sformatf("to busy%0d slave_req", i), 64'(slave_req), 64'(1));
    end
    step();
    chk("to master_ack", 64'(master_ack), 64'(4'b0001));
    chk("to timeout_err", 64'(timeout_err), 64'(1));
    chk("to master_rdata", 64'(master_rdata), 64'(0));
    chk("to slave_req", 64'(slave_req), 64'(0));
    master_req = '0;
    step();
    chk("to after master_ack", 64'(master_ack), 64'(0));
    chk("to after timeout_err", 64'(timeout_err), 64'(0));
    chk("to after busy", 64'(busy), 64'(0));

    // Ack and timeout expiry on the same edge: ack wins
    master_req = 4'b0010;
    step();
    chk("col grant_id", 64'(grant_id), 64'(1));
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("col busy%0d master_ack", i), 64'(master_ack), 64'(0));
    end
    slave_ack = 1'b1; slave_rdata = 32'h1234;
    step();
    chk("col master_ack", 64'(master_ack), 64'(4'b0010));
    chk("col timeout_err", 64'(timeout_err), 64'(0));
    chk("col master_rdata", 64'(master_rdata), 64'(32'h1234));
    slave_ack = 1'b0; master_req = '0;
    step();

    // Reset in the middle of BUSY abandons the transaction
    master_req = 4'b0100;
    step();
    chk("rst grant_id", 64'(grant_id), 64'(2));
    step();
    chk("rst busy before", 64'(busy), 64'(1));
    aresetn = 1'b1; master_req = 4'b1111;
    step();
    chk("rst slave_req", 64'(slave_req), 64'(0));
    chk("rst master_ack", 64'(master_ack), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst grant_id", 64'(grant_id), 64'(0));
    aresetn = 1'b0;
    step();
    chk("post-rst grant_id", 64'(grant_id), 64'(0));
    chk("post-rst slave_req", 64'(slave_req), 64'(1));
    chk("post-rst slave_addr", 64'(slave_addr), 64'(master_addr[0]));
    master_req = '0;
    step();
    chk("post-rst no stale ack", 64'(master_ack), 64'(0));
    slave_ack = 1'b1; slave_rdata = 32'h99;
    step();
    chk("post-rst master_ack", 64'(master_ack), 64'(4'b0001));
    chk("post-rst master_rdata", 64'(master_rdata), 64'(32'h99));
    slave_ack = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cross_bar_slave_arb.md
# cross_bar_slave_arb

Per-slave-port arbiter for `cross_bar_top`. Each instance owns one slave port, accepts requests already decoded to that slave from all `MASTER_N` master ports, and picks one winner round-robin. It then runs a single req/ack transaction to the slave and routes the ack and read data back to the winner. `cross_bar_top` instantiates `SLAVE_N` copies, all on the device clock.

## Interface

Parameters:
- `MASTER_N`, 4, number of requesting master ports (≥2).
- `ADDR_W`, 32, address width (matches `addr_t`).
- `DATA_W`, 32, data width (matches `data_t`).
- `TIMEOUT_CYC`, 16, maximum BUSY cycles before a forced completion; 0 disables the timeout.

Ports:
- `clk`, in, 1, device clock; all logic on the rising edge.
- `aresetn`, in, 1, reset; **synchronous, active-high**.
- `master_req`, in, MASTER_N, per-master request already decoded to this slave; held until acked.
- `master_addr`, in, MASTER_N×ADDR_W, per-master address.
- `master_cmd`, in, MASTER_N, per-master command; 0 = read, 1 = write.
- `master_wdata`, in, MASTER_N×DATA_W, per-master write data.
- `master_ack`, out, MASTER_N, one-hot, one-cycle completion pulse to the winner.
- `master_rdata`, out, DATA_W, read data; valid while `master_ack` is high.
- `slave_req`, out, 1, request to the slave.
- `slave_addr`, out, ADDR_W, latched address of the winner.
- `slave_cmd`, out, 1, latched command of the winner.
- `slave_wdata`, out, DATA_W, latched write data of the winner.
- `slave_ack`, in, 1, slave completion; may be a pulse or a level.
- `slave_rdata`, in, DATA_W, slave read data; sampled when `slave_ack` is high.
- `grant_id`, out, $clog2(MASTER_N), index of the current or last winner.
- `busy`, out, 1, high in BUSY and DONE.
- `timeout_err`, out, 1, one-cycle pulse aligned with a forced `master_ack`.

## Operation

- **FSM states:** IDLE → BUSY → DONE → IDLE.
- **IDLE:** eligible = `master_req` & ~`served_mask`.
  - If eligible ≠ 0, winner w = the first eligible index at or above `rr_ptr`, wrapping modulo MASTER_N.
  - On the same edge: latch `master_addr[w]`, `master_cmd[w]` and `master_wdata[w]` into the `slave_*` registers; set `grant_id`=w; set `rr_ptr`=(w+1) mod MASTER_N; set `slave_req`=1; go to BUSY.
- **BUSY:** hold `slave_*` stable and count cycles.
  - On sampling `slave_ack`=1: capture `slave_rdata` into `master_rdata` (for reads and writes), clear `slave_req`, pulse `master_ack[w]`, go to DONE.
  - If the count reaches `TIMEOUT_CYC` with no ack: clear `slave_req`, set `master_rdata`=0, pulse `master_ack[w]` and `timeout_err`, go to DONE.
- **DONE:** one cycle. `master_ack[w]` is high only in this cycle. Set `served_mask`=one-hot(w), then go to IDLE.
- **`served_mask`:** applies only in the first IDLE cycle after DONE, then clears. This lets the winner drop its request without being regranted stale. Other requesters may be granted in that same cycle.
- **Transaction latching:** a master that drops `master_req` mid-BUSY does not abort the transaction; it completes and the ack is still pulsed.
- **`slave_ack` outside BUSY:** ignored in IDLE and DONE. A level ack that is still high in IDLE does not complete anything.
- **Ack vs. timeout:** if `slave_ack` and timeout expiry fall in the same cycle, the ack wins; `timeout_err` stays 0 and the real rdata is used.
- **Reset values:** state=IDLE, `rr_ptr`=0, `served_mask`=0, count=0; `slave_req`=0, `slave_addr`/`slave_cmd`/`slave_wdata`=0, `master_ack`=0, `master_rdata`=0, `grant_id`=0, `busy`=0, `timeout_err`=0.
- **Reset mid-transaction:** abandon it. All outputs take their reset values on the next edge and no ack is issued.

## Timing

- Requests seen in IDLE at edge T give `slave_req`=1 from T+1. Grant latency is 1 cycle.
- `slave_ack` sampled at edge T+k gives `master_ack[w]`=1 and valid `master_rdata` in cycle T+k+1, with `slave_req`=0 in that same cycle.
- IDLE again at T+k+2. Minimum back-to-back spacing per slave is 3 cycles when `slave_ack` is returned in the first BUSY cycle.
- Timeout: forced DONE after exactly `TIMEOUT_CYC` BUSY cycles without an ack.
- `busy` is high exactly while in BUSY or DONE.
- `grant_id` holds its value until the next grant.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Single read:** `master_req`=4'b0100, addr 0x1000_0010, cmd 0; slave acks 2 cycles after `slave_req` with rdata 0xA5A5_0001. Expect `slave_addr`=0x1000_0010 and `grant_id`=2; `master_ack`=4'b0100 for exactly 1 cycle with `master_rdata`=0xA5A5_0001; `busy` falls 2 cycles later.
- **Round robin:** all four masters request continuously and re-raise `master_req` after each ack; slave acks immediately. Expect grant order 0,1,2,3,0; the served master is never regranted in the IDLE cycle right after its own DONE.
- **Write with held ack:** master 1, cmd 1, wdata 0xDEAD_BEEF; slave holds ack high for 3 cycles. Expect a single `master_ack` pulse; no second transaction starts while `master_req` is low.
- **Timeout:** `TIMEOUT_CYC`=16 and the slave never acks. Expect `master_ack` and `timeout_err` high together after 16 BUSY cycles, `master_rdata`=0, `slave_req`=0.
- **Ack/timeout collision:** ack arrives in BUSY cycle 16 with rdata 0x1234. Expect `timeout_err`=0 and `master_rdata`=0x1234.
- **Reset mid-BUSY:** assert `aresetn` for 1 cycle during BUSY. Expect `slave_req`, `master_ack` and `busy` at 0 on the next edge, `rr_ptr`=0, and master 0 granted first after release when all request.
